// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D round-robin scanner: FSM states, SPI command
// frame layout and the default slot-to-channel map.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        READ = 2'd3
    } a2d_state_e;

    localparam logic [1:0]  CMD_PREFIX = 2'b00;
    localparam logic [10:0] CMD_PAD    = 11'h000;

    // Slot 0 -> ch 0, slot 1 -> ch 4, slot 2 -> ch 5, slot 3 -> ch 6.
    localparam logic [11:0] DEF_CH_MAP = {3'd6, 3'd5, 3'd4, 3'd0};

    function automatic logic [15:0] cmd_frame(input logic [2:0] ch_id);
        return {CMD_PREFIX, ch_id, CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_scan_ctrl_if.sv
// SPI monarch handshake bundle between the scanner (master) and the SPI
// monarch (slave).
interface a2d_scan_ctrl_if;

    logic        spi_wrt;
    logic [15:0] spi_wt_data;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    modport master (
        output spi_wrt,
        output spi_wt_data,
        input  spi_done,
        input  spi_rd_data
    );

    modport slave (
        input  spi_wrt,
        input  spi_wt_data,
        output spi_done,
        output spi_rd_data
    );

endinterface

// File: rtl/a2d_avg_acc.sv
// Sample accumulator: sums 2^AVG_LOG2 captures and flags the capture that
// completes a result, presenting the truncated average alongside.
module a2d_avg_acc #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_capture,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_publish,
    output logic [DATA_W-1:0] o_avg
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_last;

    // The extra AVG_LOG2 bits of headroom mean the sum can never wrap.
    assign w_acc_next = r_acc + ACC_W'(i_sample);
    assign w_last     = (r_cnt == CNT_LAST);
    assign o_publish  = i_capture & w_last;
    assign o_avg      = DATA_W'(w_acc_next >> AVG_LOG2);

    // Accumulate until the final sample of the group, then start afresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_capture) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin A2D scanner: each conversion is a command frame then a read
// frame on the SPI monarch, with optional averaging and free-running scan.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int                  NUM_CH   = 4,
    parameter int                  DATA_W   = 12,
    parameter int                  AVG_LOG2 = 0,
    parameter logic [NUM_CH*3-1:0] CH_MAP   = DEF_CH_MAP,
    localparam int                 SLOT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_nxt,
    input  logic                       i_auto_en,
    a2d_scan_ctrl_if.master            spi,
    output logic [NUM_CH*DATA_W-1:0]   o_results,
    output logic [NUM_CH-1:0]          o_res_valid,
    output logic                       o_res_upd,
    output logic [SLOT_W-1:0]          o_upd_slot,
    output logic                       o_scan_done,
    output logic                       o_busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CMD  = CMD;
    localparam logic [1:0] S_GAP  = GAP;
    localparam logic [1:0] S_READ = READ;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    logic [1:0]        r_state;
    logic [SLOT_W-1:0] r_slot;
    logic [DATA_W-1:0] r_res [NUM_CH];
    logic [NUM_CH-1:0] r_valid;
    logic              r_upd;
    logic [SLOT_W-1:0] r_upd_slot;
    logic              r_scan_done;

    logic [2:0]        w_ch_map [NUM_CH];
    logic              w_start;
    logic              w_capture;
    logic              w_publish;
    logic              w_wrt;
    logic [DATA_W-1:0] w_avg;
    logic [SLOT_W-1:0] w_slot_next;
    logic              w_unused_rd;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        assign w_ch_map[g]                   = CH_MAP[3*g +: 3];
        assign o_results[DATA_W*g +: DATA_W] = r_res[g];
    end

    // nxt and auto_en together still mean a single start.
    assign w_start   = i_nxt | i_auto_en;
    assign w_capture = (r_state == S_READ) & spi.spi_done;
    // Only the low DATA_W bits carry the result.
    assign w_unused_rd = ^spi.spi_rd_data;

    assign spi.spi_wt_data = cmd_frame(w_ch_map[r_slot]);
    assign spi.spi_wrt     = w_wrt;

    assign o_res_valid = r_valid;
    assign o_res_upd   = r_upd;
    assign o_upd_slot  = r_upd_slot;
    assign o_scan_done = r_scan_done;
    assign o_busy      = (r_state != S_IDLE);

    a2d_avg_acc #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_sample  (spi.spi_rd_data[DATA_W-1:0]),
        .o_publish (w_publish),
        .o_avg     (w_avg)
    );

    // Write strobe: the start cycle in IDLE and the single GAP cycle.
    always_comb begin
        w_wrt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_wrt = 1'b1;
                end else begin
                    w_wrt = 1'b0;
                end
            end
            S_GAP:   w_wrt = 1'b1;
            default: w_wrt = 1'b0;
        endcase
    end

    // Next slot in round-robin order.
    always_comb begin
        w_slot_next = '0;
        if (r_slot == LAST_SLOT) begin
            w_slot_next = '0;
        end else begin
            w_slot_next = r_slot + SLOT_W'(1);
        end
    end

    // Conversion sequencing: command frame, one dead cycle, read frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (spi.spi_done) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP:   r_state <= S_READ;
                S_READ: begin
                    if (spi.spi_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result publication, strobes and slot advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot      <= '0;
            r_valid     <= '0;
            r_upd       <= 1'b0;
            r_upd_slot  <= '0;
            r_scan_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_upd       <= w_publish;
            r_scan_done <= w_publish & (r_slot == LAST_SLOT);
            if (w_publish) begin
                r_upd_slot <= r_slot;
                r_slot     <= w_slot_next;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_slot == SLOT_W'(i)) begin
                        r_res[i]   <= w_avg;
                        r_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl: a default instance and an averaging
// instance, each served by a behavioural SPI monarch answering 32 cycles late.
module tb_a2d_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic nxt0 = 1'b0, auto0 = 1'b0, nxt1 = 1'b0, auto1 = 1'b0;

    a2d_scan_ctrl_if if0();
    a2d_scan_ctrl_if if1();

    logic [47:0] res0, res1;
    logic [3:0]  val0, val1;
    logic        upd0, upd1, scan0, scan1, busy0, busy1;
    logic [1:0]  slot0, slot1;

    a2d_scan_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_nxt(nxt0), .i_auto_en(auto0), .spi(if0),
        .o_results(res0), .o_res_valid(val0), .o_res_upd(upd0),
        .o_upd_slot(slot0), .o_scan_done(scan0), .o_busy(busy0)
    );

    a2d_scan_ctrl #(.AVG_LOG2(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_nxt(nxt1), .i_auto_en(auto1), .spi(if1),
        .o_results(res1), .o_res_valid(val1), .o_res_upd(upd1),
        .o_upd_slot(slot1), .o_scan_done(scan1), .o_busy(busy1)
    );

    logic        wrt_w [2];
    logic [15:0] wt_w  [2];
    logic        upd_w [2];
    logic        scan_w[2];
    logic [1:0]  slot_w[2];
    logic        done_v[2] = '{1'b0, 1'b0};
    logic [15:0] rd_v  [2] = '{16'h0000, 16'h0000};

    assign wrt_w[0] = if0.spi_wrt;     assign wrt_w[1] = if1.spi_wrt;
    assign wt_w[0]  = if0.spi_wt_data; assign wt_w[1]  = if1.spi_wt_data;
    assign upd_w[0] = upd0;            assign upd_w[1] = upd1;
    assign scan_w[0] = scan0;          assign scan_w[1] = scan1;
    assign slot_w[0] = slot0;          assign slot_w[1] = slot1;
    assign if0.spi_done = done_v[0];   assign if0.spi_rd_data = rd_v[0];
    assign if1.spi_done = done_v[1];   assign if1.spi_rd_data = rd_v[1];

    logic [15:0] vals [2][16];
    int clr_seq = 0, clr_seen = 0;
    int inj_seq [2] = '{0, 0};
    int inj_seen[2] = '{0, 0};
    int cd[2] = '{0, 0}, ptr[2] = '{0, 0};
    bit phase[2] = '{1'b0, 1'b0}, rd_frame[2] = '{1'b0, 1'b0};
    int wrt_cnt[2] = '{0, 0}, upd_cnt[2] = '{0, 0}, scan_cnt[2] = '{0, 0};
    int upd_at_wrt[2] = '{0, 0}, last_slot[2] = '{0, 0};
    int last_wrt_cyc[2] = '{0, 0}, prev_wrt_cyc[2] = '{0, 0}, ch_n[2] = '{0, 0};
    logic [2:0] ch_log [2][128];
    int cyc = 0;

    int errors = 0;
    int checks = 0;

    // SPI monarch model and event monitor; observes, then drives for next cycle.
    always @(negedge clk) begin
        cyc++;
        if (clr_seq != clr_seen) begin
            clr_seen = clr_seq;
            for (int m = 0; m < 2; m++) begin
                cd[m] = 0; ptr[m] = 0; phase[m] = 1'b0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (upd_w[m]) begin
                upd_cnt[m]++;
                upd_at_wrt[m] = wrt_cnt[m];
                last_slot[m]  = int'(slot_w[m]);
            end
            if (scan_w[m]) scan_cnt[m]++;
            if (wrt_w[m]) begin
                wrt_cnt[m]++;
                prev_wrt_cyc[m] = last_wrt_cyc[m];
                last_wrt_cyc[m] = cyc;
                if (ch_n[m] < 128) ch_log[m][ch_n[m]] = wt_w[m][13:11];
                ch_n[m]++;
            end
            done_v[m] = 1'b0;
            if (cd[m] != 0) begin
                cd[m]--;
                if (cd[m] == 0) begin
                    done_v[m] = 1'b1;
                    if (rd_frame[m]) begin
                        rd_v[m] = vals[m][ptr[m]];
                        ptr[m]  = (ptr[m] + 1) % 16;
                    end
                end
            end
            if (inj_seq[m] != inj_seen[m]) begin
                inj_seen[m] = inj_seq[m];
                done_v[m]   = 1'b1;
            end
            if (wrt_w[m]) begin
                cd[m]       = 32;
                rd_frame[m] = phase[m];
                phase[m]    = ~phase[m];
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; nxt0 = 1'b0; auto0 = 1'b0; nxt1 = 1'b0; auto1 = 1'b0;
        clr_seq++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_nxt0();
        @(posedge clk); #1 nxt0 = 1'b1;
        @(posedge clk); #1 nxt0 = 1'b0;
    endtask

    task automatic wait_upd(input int m, input int target, input int bound);
        int n;
        n = 0;
        while (upd_cnt[m] < target && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (upd_cnt[m] < target) begin
            errors++;
            $display("FAIL wait_upd%0d: got %0d publishes, want %0d", m, upd_cnt[m], target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (res0 !== 48'h0)          begin errors++; $display("FAIL rst_results: got %h want 0", res0); end
        checks++; if (val0 !== 4'b0000)        begin errors++; $display("FAIL rst_valid: got %b want 0000", val0); end
        checks++; if ({upd0, scan0, busy0} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {upd0, scan0, busy0}); end
        checks++; if (if0.spi_wrt !== 1'b0)    begin errors++; $display("FAIL rst_wrt: got %b want 0", if0.spi_wrt); end
        checks++; if (if0.spi_wt_data !== 16'h0000) begin errors++; $display("FAIL rst_wt_data: got %h want 0000", if0.spi_wt_data); end
        checks++; if ({res1, val1, busy1} !== 53'h0) begin errors++; $display("FAIL rst_avg_inst: got %h want 0", {res1, val1, busy1}); end
    endtask

    task automatic test_single();
        int wb, ub, sb;
        for (int i = 0; i < 16; i++) vals[0][i] = 16'h0ABC;
        apply_reset();
        wb = wrt_cnt[0]; ub = upd_cnt[0]; sb = scan_cnt[0];
        pulse_nxt0();
        wait_upd(0, ub + 1, 200);
        checks++; if (wrt_cnt[0] - wb !== 2) begin errors++; $display("FAIL single_wrt_cnt: got %0d want 2", wrt_cnt[0] - wb); end
        checks++; if (last_wrt_cyc[0] - prev_wrt_cyc[0] !== 33) begin errors++; $display("FAIL single_wrt_gap: got %0d want 33", last_wrt_cyc[0] - prev_wrt_cyc[0]); end
        checks++; if (ch_log[0][ch_n[0]-2] !== 3'd0) begin errors++; $display("FAIL single_ch: got %0d want 0", ch_log[0][ch_n[0]-2]); end
        checks++; if (res0[11:0] !== 12'hABC) begin errors++; $display("FAIL single_result: got %h want abc", res0[11:0]); end
        checks++; if (val0 !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", val0); end
        checks++; if (last_slot[0] !== 0) begin errors++; $display("FAIL single_upd_slot: got %0d want 0", last_slot[0]); end
        checks++; if (scan_cnt[0] - sb !== 0) begin errors++; $display("FAIL single_scan: got %0d want 0", scan_cnt[0] - sb); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy0); end
    endtask

    task automatic test_scan();
        logic [2:0] exp_ch [4];
        int ub, sb, cb, exp_scan;
        exp_ch = '{3'd0, 3'd4, 3'd5, 3'd6};
        vals[0][0] = 16'h0111; vals[0][1] = 16'h0222; vals[0][2] = 16'h0333; vals[0][3] = 16'h0444;
        apply_reset();
        ub = upd_cnt[0]; sb = scan_cnt[0]; cb = ch_n[0];
        for (int i = 0; i < 4; i++) begin
            pulse_nxt0();
            wait_upd(0, ub + i + 1, 200);
            exp_scan = (i == 3) ? 1 : 0;
            checks++;
            if (ch_log[0][cb+2*i] !== exp_ch[i] || ch_log[0][cb+2*i+1] !== exp_ch[i]) begin
                errors++;
                $display("FAIL scan_ch%0d: got %0d/%0d want %0d", i, ch_log[0][cb+2*i], ch_log[0][cb+2*i+1], exp_ch[i]);
            end
            checks++; if (scan_cnt[0] - sb !== exp_scan) begin errors++; $display("FAIL scan_done%0d: got %0d want %0d", i, scan_cnt[0] - sb, exp_scan); end
            checks++; if (last_slot[0] !== i) begin errors++; $display("FAIL scan_upd_slot%0d: got %0d want %0d", i, last_slot[0], i); end
        end
        checks++; if (res0 !== 48'h444333222111) begin errors++; $display("FAIL scan_results: got %h want 444333222111", res0); end
        checks++; if (val0 !== 4'b1111) begin errors++; $display("FAIL scan_valid: got %b want 1111", val0); end
        checks++; if (if0.spi_wt_data !== 16'h0000) begin errors++; $display("FAIL scan_wrap: got %h want 0000", if0.spi_wt_data); end
    endtask

    task automatic test_avg();
        int wb, ub, cb, bad, n;
        for (int i = 0; i < 16; i++) vals[1][i] = 16'h0000;
        vals[1][0] = 16'd100; vals[1][1] = 16'd101; vals[1][2] = 16'd102; vals[1][3] = 16'd105;
        apply_reset();
        wb = wrt_cnt[1]; ub = upd_cnt[1]; cb = ch_n[1];
        @(posedge clk); #1 auto1 = 1'b1;
        wait_upd(1, ub + 1, 1000);
        auto1 = 1'b0;
        checks++; if (res1[11:0] !== 12'd102) begin errors++; $display("FAIL avg_result: got %0d want 102", res1[11:0]); end
        checks++; if (val1 !== 4'b0001) begin errors++; $display("FAIL avg_valid: got %b want 0001", val1); end
        checks++; if (upd_at_wrt[1] - wb !== 8) begin errors++; $display("FAIL avg_frames_per_upd: got %0d want 8", upd_at_wrt[1] - wb); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (ch_log[1][cb+i] !== 3'd0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL avg_channel: got %0d frames off ch0 want 0", bad); end
        n = 0;
        while (busy1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (upd_cnt[1] - ub !== 1 || busy1 !== 1'b0) begin errors++; $display("FAIL avg_partial: got upd=%0d busy=%b want 1/0", upd_cnt[1] - ub, busy1); end
    endtask

    task automatic test_auto_stop();
        int wb, ub, sb, n;
        for (int i = 0; i < 16; i++) vals[0][i] = 16'h0100 + 16'(i);
        apply_reset();
        wb = wrt_cnt[0]; ub = upd_cnt[0]; sb = scan_cnt[0];
        @(posedge clk); #1 auto0 = 1'b1;
        wait_upd(0, ub + 10, 1500);
        auto0 = 1'b0;
        n = 0;
        while (busy0 && n < 200) begin @(posedge clk); #1; n++; end
        repeat (80) @(posedge clk);
        #1;
        checks++; if (wrt_cnt[0] - wb !== 22) begin errors++; $display("FAIL auto_wrt_cnt: got %0d want 22", wrt_cnt[0] - wb); end
        checks++; if (upd_cnt[0] - ub !== 11) begin errors++; $display("FAIL auto_upd_cnt: got %0d want 11", upd_cnt[0] - ub); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL auto_busy: got %b want 0", busy0); end
        checks++; if (res0 !== 48'h10710A109108) begin errors++; $display("FAIL auto_results: got %h want 10710a109108", res0); end
        checks++; if (last_slot[0] !== 2) begin errors++; $display("FAIL auto_last_slot: got %0d want 2", last_slot[0]); end
        checks++; if (scan_cnt[0] - sb !== 2) begin errors++; $display("FAIL auto_scan_cnt: got %0d want 2", scan_cnt[0] - sb); end
    endtask

    task automatic test_reset_mid();
        int wb, ub, n;
        for (int i = 0; i < 16; i++) vals[0][i] = 16'h0555;
        apply_reset();
        wb = wrt_cnt[0]; ub = upd_cnt[0];
        pulse_nxt0();
        n = 0;
        while (wrt_cnt[0] - wb < 2 && n < 100) begin @(posedge clk); #1; n++; end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (upd_cnt[0] - ub !== 0) begin errors++; $display("FAIL rmid_upd: got %0d want 0", upd_cnt[0] - ub); end
        checks++; if ({res0, val0} !== 52'h0) begin errors++; $display("FAIL rmid_results: got %h want 0", {res0, val0}); end
        checks++; if (busy0 !== 1'b0 || wrt_cnt[0] - wb !== 2) begin errors++; $display("FAIL rmid_idle: got busy=%b wrt=%0d want 0/2", busy0, wrt_cnt[0] - wb); end
        pulse_nxt0();
        wait_upd(0, ub + 1, 200);
        checks++; if (ch_log[0][ch_n[0]-2] !== 3'd0) begin errors++; $display("FAIL rmid_next_ch: got %0d want 0", ch_log[0][ch_n[0]-2]); end
        checks++; if (res0[11:0] !== 12'h555 || val0 !== 4'b0001) begin errors++; $display("FAIL rmid_next_result: got %h/%b want 555/0001", res0[11:0], val0); end
    endtask

    task automatic test_ignored();
        int wb, ub;
        for (int i = 0; i < 16; i++) vals[0][i] = 16'h0777;
        apply_reset();
        wb = wrt_cnt[0]; ub = upd_cnt[0];
        @(posedge clk); #1 inj_seq[0]++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0 || upd_cnt[0] - ub !== 0) begin errors++; $display("FAIL ign_idle_done: got busy=%b upd=%0d want 0/0", busy0, upd_cnt[0] - ub); end
        pulse_nxt0();
        repeat (5) @(posedge clk);
        #1 nxt0 = 1'b1;
        @(posedge clk); #1 nxt0 = 1'b0;
        wait_upd(0, ub + 1, 200);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (wrt_cnt[0] - wb !== 2) begin errors++; $display("FAIL ign_wrt_cnt: got %0d want 2", wrt_cnt[0] - wb); end
        checks++; if (upd_cnt[0] - ub !== 1 || busy0 !== 1'b0) begin errors++; $display("FAIL ign_upd: got upd=%0d busy=%b want 1/0", upd_cnt[0] - ub, busy0); end
        checks++; if (res0[11:0] !== 12'h777) begin errors++; $display("FAIL ign_result: got %h want 777", res0[11:0]); end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) vals[m][i] = 16'h0000;
        end
        test_reset();
        test_single();
        test_scan();
        test_avg();
        test_auto_stop();
        test_reset_mid();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
